// File: rtl/ram_loader.sv
// ram_loader: sequences a program load into the 16x8 RAM and arbitrates the
// RAM port between the byte-stream loader and the CPU.
//
// While a session is in progress the CPU is held and the loader owns the RAM.
// A one-cycle release state then pulses cpu_restart/load_done before the CPU
// gets the port back.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   load_start                  start a load session (honoured in IDLE only)
//   in_valid/in_data/in_last    byte stream; in_ready = accepted this cycle
//   cpu_addr/cpu_we/cpu_wdata   CPU side of the RAM port (MI/RI path)
//   ram_addr/ram_we/ram_wdata   arbitrated RAM port
//   cpu_hold                    freeze CPU step counter
//   cpu_restart                 one-cycle pulse: clear PC and microstep
//   load_done                   one-cycle pulse at session completion
//   busy                        loader owns the RAM
module ram_loader #(
  parameter int unsigned DEPTH     = 16,
  parameter bit          FILL_ZERO = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_wdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  output logic          cpu_hold,
  output logic          cpu_restart,
  output logic          load_done,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StFill, StRelease} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready    = 1'b0;
    cpu_hold    = 1'b0;
    cpu_restart = 1'b0;
    load_done   = 1'b0;
    busy        = 1'b0;
    ram_addr    = cnt_q;
    ram_we      = 1'b0;
    ram_wdata   = 8'h00;

    unique case (state_q)
      StIdle: begin
        // CPU owns the RAM port.
        ram_addr  = cpu_addr;
        ram_we    = cpu_we;
        ram_wdata = cpu_wdata;
        if (load_start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end

      StLoad: begin
        busy      = 1'b1;
        cpu_hold  = 1'b1;
        in_ready  = 1'b1;
        // Write happens in the same cycle as the handshake.
        ram_we    = in_valid;
        ram_wdata = in_data;
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            // Memory full: in_last is irrelevant, counter wraps to 0.
            state_d = StRelease;
          end else if (in_last) begin
            state_d = FILL_ZERO ? StFill : StRelease;
          end
        end
      end

      StFill: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        ram_we   = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StRelease;
        end
      end

      StRelease: begin
        // Port is still withheld from the CPU, but nothing is written.
        busy        = 1'b1;
        cpu_hold    = 1'b1;
        cpu_restart = 1'b1;
        load_done   = 1'b1;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule
